// File: rtl/irq_vector_ctrl.sv
// rtl/irq_vector_ctrl.sv - vectored interrupt controller; nesting enabled by macro IRQ_NEST_EN
module irq_vector_ctrl #(
  parameter int          NCH        = 4,
  parameter int          AW         = 32,
  parameter logic [31:0] VEC_BASE   = 32'h0000,
  parameter logic [31:0] VEC_STRIDE = 32'h0050,
  localparam int         CW         = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NCH-1:0] in_irq,
  input  logic          in_mask_we,
  input  logic [NCH-1:0] in_mask,
  input  logic          in_vec_we,
  input  logic [CW-1:0] in_vec_sel,
  input  logic [AW-1:0] in_vec_data,
  input  logic          in_ack,
  input  logic          in_eoi,
  output logic          out_int,
  output logic [AW-1:0] out_addr,
  output logic [CW-1:0] out_code,
  output logic          out_busy
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state;
  state_t          state_next;
  logic [NCH-1:0]  irq_q;
  logic [NCH-1:0]  pending;
  logic [NCH-1:0]  in_service;
  logic [NCH-1:0]  mask;
  logic [AW-1:0]   vec_table [NCH];

  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  permitted;
  logic [NCH-1:0]  eligible;
  logic [NCH-1:0]  eoi_clr;
  logic [NCH-1:0]  ack_mask;
  logic [NCH-1:0]  pending_next;
  logic [NCH-1:0]  in_service_next;
  logic            any_is;
  logic [CW-1:0]   hi_is;
  logic            found;
  logic [CW-1:0]   winner;
  logic            ack_fire;

  function automatic logic [AW-1:0] reset_vec(input int idx);
    logic [31:0] v;
    v = VEC_BASE + VEC_STRIDE * 32'(idx);
    return AW'(v);
  endfunction

  // Highest in-service channel: target of eoi and floor for nesting priority.
  always_comb begin
    any_is = 1'b0;
    hi_is  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (in_service[i]) begin
        any_is = 1'b1;
        hi_is  = CW'(i);
      end
    end
  end

  // Eligibility and highest-index winner selection.
  always_comb begin
    permitted = '0;
    found     = 1'b0;
    winner    = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef IRQ_NEST_EN
      permitted[i] = !any_is || (CW'(i) > hi_is);
`else
      permitted[i] = !any_is;
`endif
    end
    eligible = pending & ~mask & permitted;
    for (int i = 0; i < NCH; i++) begin
      if (eligible[i]) begin
        found  = 1'b1;
        winner = CW'(i);
      end
    end
  end

  // Pending / in-service updates; eoi is applied before ack so a same-cycle
  // pair retires the old handler and then records the new one.
  always_comb begin
    rise            = in_irq & ~irq_q;
    ack_fire        = (state == REQ) && in_ack;
    ack_mask        = ack_fire ? (NCH'(1) << out_code) : '0;
    eoi_clr         = (in_eoi && any_is) ? (NCH'(1) << hi_is) : '0;
    pending_next    = (pending & ~ack_mask) | rise;
    in_service_next = (in_service & ~eoi_clr) | ack_mask;
  end

  // FSM next-state: present a vector until the CPU acknowledges it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found)  state_next = REQ;
      REQ:     if (in_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Channel bookkeeping: edge history, pending, in-service, busy flag, mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q      <= '0;
      pending    <= '0;
      in_service <= '0;
      out_busy   <= 1'b0;
      mask       <= '1;
    end else begin
      irq_q      <= in_irq;
      pending    <= pending_next;
      in_service <= in_service_next;
      out_busy   <= |in_service_next;
      if (in_mask_we) mask <= in_mask;
    end
  end

  // Vector table; writes to entries beyond NCH-1 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) vec_table[i] <= reset_vec(i);
    end else if (in_vec_we && (32'(in_vec_sel) < NCH)) begin
      vec_table[in_vec_sel] <= in_vec_data;
    end
  end

  // Latch the winner on entry to REQ; held constant while presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_code <= '0;
      out_addr <= '0;
    end else if (state == IDLE && found) begin
      out_code <= winner;
      out_addr <= vec_table[winner];
    end
  end

  assign out_int = (state == REQ);

endmodule
